// File: rtl/dp_ram_capture_pkg.sv
// Shared constants for the multi-channel capture RAM: register map,
// CTRL/STATUS bit positions and FSM state encodings.
package dp_ram_capture_pkg;

  // Register addresses
  localparam logic [2:0] ADDR_DATA   = 3'd0;
  localparam logic [2:0] ADDR_RD_PTR = 3'd1;
  localparam logic [2:0] ADDR_CTRL   = 3'd2;
  localparam logic [2:0] ADDR_ID     = 3'd3;
  localparam logic [2:0] ADDR_STATUS = 3'd4;

  // CTRL fields
  localparam int unsigned CTRL_ARM_BIT    = 0;
  localparam int unsigned CTRL_WRAP_BIT   = 1;
  localparam int unsigned CTRL_CLEAR_BIT  = 2;
  localparam int unsigned CTRL_CHSEL_LSB  = 8;
  localparam int unsigned CTRL_CHSEL_MSB  = 11;

  // STATUS fields
  localparam int unsigned STATUS_STATE_LSB   = 0;
  localparam int unsigned STATUS_OVERRUN_BIT = 2;
  localparam int unsigned STATUS_FILL_LSB    = 16;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ARMED = 2'd1,
    ST_DONE  = 2'd2
  } cap_state_e;

endpackage

// File: rtl/capture_ram_sdp.sv
// Simple dual-port single-clock RAM with a registered read port.
// Ports: clk; we/waddr/wdata write port; raddr read address;
// rdata holds mem[raddr] sampled at the previous edge. Contents are not reset.
module capture_ram_sdp #(
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned ADDR_WIDTH = 11
) (
  input  logic                  clk,
  input  logic                  we,
  input  logic [ADDR_WIDTH-1:0] waddr,
  input  logic [DATA_WIDTH-1:0] wdata,
  input  logic [ADDR_WIDTH-1:0] raddr,
  output logic [DATA_WIDTH-1:0] rdata
);

  localparam int unsigned DEPTH = 2 ** ADDR_WIDTH;

  logic [DATA_WIDTH-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
    rdata <= mem[raddr];
  end

endmodule

// File: rtl/dp_ram_capture_mc.sv
// Multi-channel sample capture into a shared RAM, read back over Avalon-MM.
// Ports: avalon_clock, resetn (async active-low); read/write/address/
// writedata/readdata Avalon-MM slave (1-cycle read latency); arith_valid/
// arith_ch/arith_data sample input; capture_done high in DONE state.
module dp_ram_capture_mc
  import dp_ram_capture_pkg::*;
#(
  parameter int ID         = 1,
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 11,
  parameter int NCH        = 2
) (
  input  logic                               avalon_clock,
  input  logic                               resetn,
  input  logic                               read,
  input  logic                               write,
  input  logic [2:0]                         address,
  input  logic [31:0]                        writedata,
  output logic [31:0]                        readdata,
  input  logic                               arith_valid,
  input  logic [((NCH > 1) ? $clog2(NCH) : 1)-1:0] arith_ch,
  input  logic [DATA_WIDTH-1:0]              arith_data,
  output logic                               capture_done
);

  localparam int unsigned REG_DEPTH = (2 ** ADDR_WIDTH) / NCH;
  localparam int unsigned PTR_W     = $clog2(REG_DEPTH);
  localparam int unsigned CH_W      = (NCH > 1) ? $clog2(NCH) : 1;
  localparam int unsigned FILL_W    = PTR_W + 1;
  localparam logic [CH_W-1:0]   CH_MASK = CH_W'(NCH - 1);
  localparam logic [FILL_W-1:0] FULL    = FILL_W'(REG_DEPTH);

  cap_state_e        state, state_nxt;
  logic [PTR_W-1:0]  rd_ptr;
  logic [PTR_W-1:0]  wr_ptr [NCH];
  logic [FILL_W-1:0] fill   [NCH];
  logic              overrun, wrap, inhibit;
  logic [CH_W-1:0]   ch_sel;

  logic              ctrl_wr, ctrl_arm, ctrl_clear;
  logic [CH_W-1:0]   wr_ch;
  logic              all_full, ch_full, accept, store, data_rd;
  logic [ADDR_WIDTH-1:0] ram_waddr, ram_raddr;
  logic [DATA_WIDTH-1:0] ram_q;
  logic [31:0]       status_word;
  logic              unused_wdata;

  assign unused_wdata = ^writedata;

  // Decode of bus strobes and sample acceptance
  always_comb begin
    ctrl_wr    = write && (address == ADDR_CTRL);
    ctrl_arm   = writedata[CTRL_ARM_BIT];
    ctrl_clear = writedata[CTRL_CLEAR_BIT];
    wr_ch      = arith_ch & CH_MASK;
    all_full   = 1'b1;
    for (int i = 0; i < NCH; i++) begin
      if (fill[i] != FULL) all_full = 1'b0;
    end
    ch_full    = (fill[wr_ch] == FULL);
    // A clear in the same cycle wins over the incoming sample
    accept     = arith_valid && (state == ST_ARMED) && !(ctrl_wr && ctrl_clear);
    store      = accept && (wrap || !ch_full);
    data_rd    = read && (address == ADDR_DATA) && !inhibit;
    ram_waddr  = (ADDR_WIDTH'(wr_ch) << PTR_W) | ADDR_WIDTH'(wr_ptr[wr_ch]);
    ram_raddr  = (ADDR_WIDTH'(ch_sel) << PTR_W) | ADDR_WIDTH'(rd_ptr);
    status_word = (32'(fill[ch_sel]) << STATUS_FILL_LSB)
                | (32'(overrun) << STATUS_OVERRUN_BIT)
                | (32'(state) << STATUS_STATE_LSB);
  end

  // FSM next state; arm=1 always lands in ARMED, so clear+arm stays armed
  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE:  if (ctrl_wr && ctrl_arm) state_nxt = ST_ARMED;
      ST_ARMED: begin
        if (ctrl_wr)                state_nxt = ctrl_arm ? ST_ARMED : ST_IDLE;
        else if (!wrap && all_full) state_nxt = ST_DONE;
      end
      ST_DONE:  if (ctrl_wr)       state_nxt = ctrl_arm ? ST_ARMED : ST_IDLE;
      default:  state_nxt = ST_IDLE;
    endcase
  end

  // FSM state register and done flag
  always_ff @(posedge avalon_clock or negedge resetn) begin
    if (!resetn) begin
      state        <= ST_IDLE;
      capture_done <= 1'b0;
    end else begin
      state        <= state_nxt;
      capture_done <= (state_nxt == ST_DONE);
    end
  end

  // Control latches, pointers, fill counters and overrun
  always_ff @(posedge avalon_clock or negedge resetn) begin
    if (!resetn) begin
      wrap    <= 1'b0;
      ch_sel  <= '0;
      rd_ptr  <= '0;
      overrun <= 1'b0;
      inhibit <= 1'b0;
      for (int i = 0; i < NCH; i++) begin
        wr_ptr[i] <= '0;
        fill[i]   <= '0;
      end
    end else begin
      if (ctrl_wr) begin
        wrap   <= writedata[CTRL_WRAP_BIT];
        ch_sel <= CH_W'(writedata[CTRL_CHSEL_MSB:CTRL_CHSEL_LSB]) & CH_MASK;
      end

      // One pointer step per contiguous read burst on DATA
      if (!read)        inhibit <= 1'b0;
      else if (data_rd) inhibit <= 1'b1;

      if (ctrl_wr && ctrl_clear) begin
        rd_ptr  <= '0;
        overrun <= 1'b0;
        for (int i = 0; i < NCH; i++) begin
          wr_ptr[i] <= '0;
          fill[i]   <= '0;
        end
      end else begin
        if (write && (address == ADDR_RD_PTR)) rd_ptr <= writedata[PTR_W-1:0];
        else if (data_rd)                      rd_ptr <= rd_ptr + PTR_W'(1);

        if (accept && ch_full && !wrap) overrun <= 1'b1;

        if (store) begin
          wr_ptr[wr_ch] <= wr_ptr[wr_ch] + PTR_W'(1);
          if (!ch_full) fill[wr_ch] <= fill[wr_ch] + FILL_W'(1);
        end
      end
    end
  end

  // Register read mux, 1-cycle latency
  always_ff @(posedge avalon_clock or negedge resetn) begin
    if (!resetn) begin
      readdata <= '0;
    end else if (read) begin
      case (address)
        ADDR_DATA:   readdata <= 32'(ram_q);
        ADDR_RD_PTR: readdata <= 32'(rd_ptr);
        ADDR_ID:     readdata <= 32'(ID);
        ADDR_STATUS: readdata <= status_word;
        default:     readdata <= '0;
      endcase
    end
  end

  capture_ram_sdp #(
    .DATA_WIDTH(DATA_WIDTH),
    .ADDR_WIDTH(ADDR_WIDTH)
  ) u_ram (
    .clk   (avalon_clock),
    .we    (store),
    .waddr (ram_waddr),
    .wdata (arith_data),
    .raddr (ram_raddr),
    .rdata (ram_q)
  );

endmodule

// File: tb/tb_dp_ram_capture_mc.sv
// Scoreboard bench for dp_ram_capture_mc with NCH=2, ADDR_WIDTH=4 (8 words/channel).
module tb_dp_ram_capture_mc;

  localparam int TB_ID  = 'h1234;
  localparam int DW     = 16;
  localparam int AW     = 4;
  localparam int TB_NCH = 2;

  localparam logic [2:0] A_DATA = 3'd0, A_RDPTR = 3'd1, A_CTRL = 3'd2,
                         A_ID = 3'd3, A_STATUS = 3'd4;

  logic          avalon_clock = 1'b0;
  logic          resetn       = 1'b0;
  logic          read         = 1'b0;
  logic          write        = 1'b0;
  logic [2:0]    address      = '0;
  logic [31:0]   writedata    = '0;
  logic [31:0]   readdata;
  logic          arith_valid  = 1'b0;
  logic [0:0]    arith_ch     = '0;
  logic [DW-1:0] arith_data   = '0;
  logic          capture_done;

  dp_ram_capture_mc #(
    .ID(TB_ID), .DATA_WIDTH(DW), .ADDR_WIDTH(AW), .NCH(TB_NCH)
  ) dut (
    .avalon_clock (avalon_clock),
    .resetn       (resetn),
    .read         (read),
    .write        (write),
    .address      (address),
    .writedata    (writedata),
    .readdata     (readdata),
    .arith_valid  (arith_valid),
    .arith_ch     (arith_ch),
    .arith_data   (arith_data),
    .capture_done (capture_done)
  );

  always #5 avalon_clock = ~avalon_clock;

  int checks = 0;
  int errors = 0;

  logic [31:0] exp_q  [$];
  string       name_q [$];
  bit          dc_q   [$];

  // readdata is valid the cycle after read is sampled
  logic rvalid = 1'b0;
  always @(posedge avalon_clock) rvalid <= read;

  logic [31:0] mon_exp;
  string       mon_name;
  bit          mon_dc;

  // Monitor: pop and compare whenever a read response is presented
  initial begin
    forever begin
      @(negedge avalon_clock);
      if (rvalid) begin
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_read: got %h, required no pending read", readdata);
        end else begin
          mon_exp  = exp_q.pop_front();
          mon_name = name_q.pop_front();
          mon_dc   = dc_q.pop_front();
          if (!mon_dc) begin
            checks++;
            if (readdata !== mon_exp) begin
              errors++;
              $display("FAIL %s: got %h, required %h", mon_name, readdata, mon_exp);
            end
          end
        end
      end
    end
  end

  task automatic expect_rd(input logic [31:0] e, input string n, input bit dc);
    exp_q.push_back(e);
    name_q.push_back(n);
    dc_q.push_back(dc);
  endtask

  task automatic bus_wr(input logic [2:0] a, input logic [31:0] d);
    address = a; writedata = d; write = 1'b1;
    @(posedge avalon_clock); #1;
    write = 1'b0;
    @(posedge avalon_clock); #1;
  endtask

  task automatic bus_rd(input logic [2:0] a, input logic [31:0] e, input string n);
    address = a; read = 1'b1;
    expect_rd(e, n, 1'b0);
    @(posedge avalon_clock); #1;
    read = 1'b0;
    @(posedge avalon_clock); #1;
  endtask

  task automatic sample(input logic ch, input logic [DW-1:0] d);
    arith_valid = 1'b1; arith_ch = ch; arith_data = d;
    @(posedge avalon_clock); #1;
    arith_valid = 1'b0;
  endtask

  task automatic check_pin(input logic act, input logic req, input string n);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %b, required %b", n, act, req);
    end
  endtask

  task automatic check_word(input logic [31:0] act, input logic [31:0] req, input string n);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %h, required %h", n, act, req);
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout, required completion");
    $fatal(1, "watchdog");
  end

  initial begin
    // Reset state
    repeat (2) @(posedge avalon_clock); #1;
    check_pin(capture_done, 1'b0, "rst_capture_done");
    check_word(readdata, 32'h0, "rst_readdata");
    resetn = 1'b1;
    @(posedge avalon_clock); #1;
    bus_rd(A_STATUS, 32'h0, "rst_status");
    bus_rd(A_RDPTR,  32'h0, "rst_rd_ptr");

    // ID and unmapped address
    bus_rd(A_ID, 32'(TB_ID), "id");
    bus_wr(A_ID, 32'hFFFF_FFFF);
    bus_rd(A_ID, 32'(TB_ID), "id_after_write");
    bus_rd(3'd5, 32'h0, "addr5");

    // Full capture on both channels -> DONE
    bus_wr(A_CTRL, 32'h1);
    bus_rd(A_STATUS, 32'h1, "armed_status");
    for (int i = 0; i < 8; i++) sample(1'b0, DW'(i));
    for (int i = 0; i < 8; i++) sample(1'b1, DW'(10 + i));
    repeat (2) @(posedge avalon_clock); #1;
    check_pin(capture_done, 1'b1, "done_flag");
    bus_rd(A_STATUS, 32'h0008_0002, "done_status");
    bus_wr(A_CTRL, 32'h100);
    check_pin(capture_done, 1'b0, "done_cleared");
    bus_rd(A_STATUS, 32'h0008_0000, "ch1_status");
    bus_wr(A_RDPTR, 32'h0);
    for (int i = 0; i < 8; i++) bus_rd(A_DATA, 32'(10 + i), $sformatf("ch1_data%0d", i));

    // Held read advances rd_ptr once
    bus_wr(A_RDPTR, 32'h2);
    address = A_DATA; read = 1'b1;
    for (int i = 0; i < 3; i++) expect_rd(32'h0, "held", 1'b1);
    repeat (3) @(posedge avalon_clock); #1;
    read = 1'b0;
    @(posedge avalon_clock); #1;
    bus_rd(A_RDPTR, 32'h3, "held_rd_ptr");
    bus_rd(A_DATA, 32'd13, "held_next_data");

    // No wrap: 9th sample to ch0 dropped, overrun set
    bus_wr(A_CTRL, 32'h5);
    for (int i = 0; i < 8; i++) sample(1'b0, DW'(i));
    sample(1'b0, DW'(99));
    bus_rd(A_STATUS, 32'h0008_0005, "overrun_status");
    bus_rd(A_DATA, 32'h0, "overrun_not_written");

    // Wrap: samples 0..9 to ch0 read back as 8,9,2..7
    bus_wr(A_CTRL, 32'h7);
    for (int i = 0; i < 10; i++) sample(1'b0, DW'(i));
    bus_rd(A_STATUS, 32'h0008_0001, "wrap_status");
    for (int i = 0; i < 8; i++)
      bus_rd(A_DATA, (i < 2) ? 32'(8 + i) : 32'(i), $sformatf("wrap_data%0d", i));

    // Clear+arm concurrent with a sample
    address = A_CTRL; writedata = 32'h5; write = 1'b1;
    arith_valid = 1'b1; arith_ch = 1'b1; arith_data = DW'(55);
    @(posedge avalon_clock); #1;
    write = 1'b0; arith_valid = 1'b0;
    @(posedge avalon_clock); #1;
    bus_rd(A_STATUS, 32'h0000_0001, "clear_ch0_status");
    bus_wr(A_CTRL, 32'h101);
    bus_rd(A_STATUS, 32'h0000_0001, "clear_ch1_status");

    // Reset mid-capture keeps RAM contents
    bus_wr(A_CTRL, 32'h1);
    sample(1'b0, DW'(40));
    sample(1'b0, DW'(41));
    sample(1'b0, DW'(42));
    resetn = 1'b0;
    #2;
    check_pin(capture_done, 1'b0, "midrst_done");
    check_word(readdata, 32'h0, "midrst_readdata");
    #20;
    resetn = 1'b1;
    @(posedge avalon_clock); #1;
    bus_rd(A_STATUS, 32'h0, "midrst_status");
    bus_rd(A_DATA, 32'd40, "midrst_data0");
    bus_rd(A_DATA, 32'd41, "midrst_data1");

    // ARMED -> IDLE on arm=0
    bus_wr(A_CTRL, 32'h1);
    bus_rd(A_STATUS, 32'h1, "rearm_status");
    bus_wr(A_CTRL, 32'h0);
    bus_rd(A_STATUS, 32'h0, "disarm_status");

    repeat (4) @(posedge avalon_clock); #1;
    if (exp_q.size() != 0) begin
      checks++;
      errors++;
      $display("FAIL drain: got %0d pending, required 0", exp_q.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
